// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;
  localparam int FWD_NONE = 0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  reg_write;
    logic                  mem_read;
  } hz_entry_t;

endpackage

// File: rtl/pipe_fwd_match.sv
// Priority match of one source operand against all in-flight entries.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  hz_entry_t [NUM_STAGES-1:0] i_entries,
  input  logic [REG_ADDR_W-1:0]      i_reg,
  input  logic                       i_use,
  output logic [SEL_W-1:0]           o_sel,
  output logic                       o_load_haz
);

  logic [NUM_STAGES-1:0] w_hit;

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_hit[i] = i_entries[i].valid & i_entries[i].reg_write &
                 (i_entries[i].dest == i_reg) & (i_reg != REG_ZERO) & i_use;
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites the select.
  always_comb begin
    o_sel      = SEL_W'(FWD_NONE);
    o_load_haz = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (w_hit[i]) o_sel = SEL_W'(i + 1);
    end
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (w_hit[i] && i_entries[i].mem_read) o_load_haz = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: tracks in-flight writers, drives stall, flush
// and per-operand forwarding selects for the ID stage.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_jump,
  input  logic                  ex_branch_taken,
  output logic                  stall,
  output logic                  flush_if_id,
  output logic [SEL_W-1:0]      fwd_sel_rs,
  output logic [SEL_W-1:0]      fwd_sel_rt,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [31:0]           stall_count
);

  import pipe_pkg::hz_entry_t;

  hz_entry_t [NUM_STAGES-1:0] r_entries;
  logic [31:0]                r_stall_count;
  logic                       w_haz_rs;
  logic                       w_haz_rt;
  logic                       w_stall;

  pipe_fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W)
  ) u_match_rs (
    .i_entries  (r_entries),
    .i_reg      (id_rs),
    .i_use      (id_uses_rs),
    .o_sel      (fwd_sel_rs),
    .o_load_haz (w_haz_rs)
  );

  pipe_fwd_match #(
    .NUM_STAGES (NUM_STAGES),
    .LOAD_LAT   (LOAD_LAT),
    .SEL_W      (SEL_W)
  ) u_match_rt (
    .i_entries  (r_entries),
    .i_reg      (id_rt),
    .i_use      (id_uses_rt),
    .o_sel      (fwd_sel_rt),
    .o_load_haz (w_haz_rt)
  );

  // A taken branch kills the ID instruction, so it never needs to wait.
  assign w_stall     = id_valid & (w_haz_rs | w_haz_rt) & ~ex_branch_taken;
  assign stall       = w_stall;
  assign flush_if_id = ex_branch_taken | (id_jump & id_valid & ~w_stall);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entries     <= '0;
      r_stall_count <= '0;
    end else begin
      for (int i = NUM_STAGES - 1; i >= 1; i--) begin
        r_entries[i] <= r_entries[i-1];
      end
      if (ex_branch_taken || w_stall) begin
        r_entries[0] <= '0;
      end else begin
        r_entries[0].valid     <= id_valid;
        r_entries[0].dest      <= id_dest;
        r_entries[0].reg_write <= id_reg_write;
        r_entries[0].mem_read  <= id_mem_read;
      end
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) stage_valid[i] = r_entries[i].valid;
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: directed vector table, reset/stall corner sequence and
// randomized traffic compared against an instruction-history reference model.
module tb_pipe_hazard_unit;

  localparam int NS = 3;
  localparam int LL = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_jump;
  logic       ex_branch_taken;
  logic       stall, flush_if_id;
  logic [1:0] fwd_sel_rs, fwd_sel_rt;
  logic [2:0] stage_valid;
  logic [31:0] stall_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_dest         (id_dest),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .id_jump         (id_jump),
    .ex_branch_taken (ex_branch_taken),
    .stall           (stall),
    .flush_if_id     (flush_if_id),
    .fwd_sel_rs      (fwd_sel_rs),
    .fwd_sel_rt      (fwd_sel_rt),
    .stage_valid     (stage_valid),
    .stall_count     (stall_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic rw, input logic mr, input logic jmp, input logic br);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dest = dest; id_reg_write = rw; id_mem_read = mr; id_jump = jmp;
    ex_branch_taken = br;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic v; logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    logic [4:0] dest; logic rw; logic mr; logic jmp; logic br;
    logic e_stall; logic e_flush; logic [1:0] e_rs; logic [1:0] e_rt; logic [2:0] e_sv;
  } vec_t;

  vec_t vecs[21];

  // Reference model: history of what entered EX on each of the last NS cycles.
  typedef struct { logic v; logic [4:0] dest; logic rw; logic mr; } hist_t;
  hist_t hist[NS];
  logic [31:0] m_cnt;

  function automatic logic [1:0] m_sel(input logic [4:0] r, input logic use_r);
    if (!use_r || r == 5'd0) return 2'd0;
    for (int age = 1; age <= NS; age++) begin
      if (hist[age-1].v && hist[age-1].rw && hist[age-1].dest == r) return 2'(age);
    end
    return 2'd0;
  endfunction

  function automatic logic m_loaduse(input logic [4:0] r, input logic use_r);
    if (!use_r || r == 5'd0) return 1'b0;
    for (int age = 1; age <= LL; age++) begin
      if (hist[age-1].v && hist[age-1].rw && hist[age-1].mr && hist[age-1].dest == r) return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    logic e_st, e_fl;
    logic [2:0] e_sv;

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //            v rs rt urs urt dest rw mr j br  st fl rs rt sv
    vecs[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0};
    vecs[1]  = '{1, 3, 5, 1, 1, 4, 1, 0, 0, 0,  0, 0, 1, 0, 1};
    vecs[2]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 3};
    vecs[3]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7};
    vecs[4]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 2, 7};
    vecs[5]  = '{1, 1, 2, 1, 1, 7, 1, 0, 0, 0,  0, 0, 0, 0, 7};
    vecs[6]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7};
    vecs[7]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7};
    vecs[8]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 3, 7};
    vecs[9]  = '{1, 0, 7, 0, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 7};
    vecs[10] = '{1, 0, 0, 0, 0, 8, 1, 1, 0, 0,  0, 0, 0, 0, 7};
    vecs[11] = '{1, 8, 1, 1, 1, 9, 1, 0, 0, 0,  1, 0, 1, 0, 7};
    vecs[12] = '{1, 8, 1, 1, 1, 9, 1, 0, 0, 0,  0, 0, 2, 0, 6};
    vecs[13] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 5};
    vecs[14] = '{1, 0, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3};
    vecs[15] = '{1, 0, 0, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0, 7};
    vecs[16] = '{1, 10, 0, 1, 0, 12, 1, 0, 0, 1, 0, 1, 1, 0, 7};
    vecs[17] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 6};
    vecs[18] = '{1, 0, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 0, 0, 5};
    vecs[19] = '{1, 11, 0, 1, 0, 13, 1, 0, 1, 0, 1, 0, 1, 0, 3};
    vecs[20] = '{1, 11, 0, 1, 0, 13, 1, 0, 1, 0, 0, 1, 2, 0, 6};

    do_reset();
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_flush", {31'd0, flush_if_id}, 32'd0);
    chk("reset_stage_valid", {29'd0, stage_valid}, 32'd0);
    chk("reset_stall_count", stall_count, 32'd0);

    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      drive(vecs[k].v, vecs[k].rs, vecs[k].rt, vecs[k].urs, vecs[k].urt, vecs[k].dest,
            vecs[k].rw, vecs[k].mr, vecs[k].jmp, vecs[k].br);
      #1;
      chk($sformatf("vec%0d_stall", k), {31'd0, stall}, {31'd0, vecs[k].e_stall});
      chk($sformatf("vec%0d_flush", k), {31'd0, flush_if_id}, {31'd0, vecs[k].e_flush});
      chk($sformatf("vec%0d_fwd_rs", k), {30'd0, fwd_sel_rs}, {30'd0, vecs[k].e_rs});
      chk($sformatf("vec%0d_fwd_rt", k), {30'd0, fwd_sel_rt}, {30'd0, vecs[k].e_rt});
      chk($sformatf("vec%0d_stage_valid", k), {29'd0, stage_valid}, {29'd0, vecs[k].e_sv});
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("table_stall_count", stall_count, 32'd2);
    chk("table_final_stage_valid", {29'd0, stage_valid}, 32'd5);

    // Reset asserted in the middle of a load-use stall.
    do_reset();
    drive(1, 0, 0, 0, 0, 8, 1, 1, 0, 0);
    @(negedge clk);
    drive(1, 8, 1, 1, 1, 9, 1, 0, 0, 0);
    #1;
    chk("rst_mid_stall_pre", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_mid_stage_valid", {29'd0, stage_valid}, 32'd0);
    chk("rst_mid_stall_count", stall_count, 32'd0);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_fwd_rs", {30'd0, fwd_sel_rs}, 32'd0);
    id_jump = 1'b1;
    #1;
    chk("rst_mid_jump_flush", {31'd0, flush_if_id}, 32'd1);

    // Randomized traffic against the history model.
    do_reset();
    for (int i = 0; i < NS; i++) hist[i] = '{0, 0, 0, 0};
    m_cnt = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      drive(($urandom_range(0, 9) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      #1;
      e_st = id_valid && !ex_branch_taken &&
             (m_loaduse(id_rs, id_uses_rs) || m_loaduse(id_rt, id_uses_rt));
      e_fl = ex_branch_taken || (id_jump && id_valid && !e_st);
      for (int i = 0; i < NS; i++) e_sv[i] = hist[i].v;
      chk("rnd_stall", {31'd0, stall}, {31'd0, e_st});
      chk("rnd_flush", {31'd0, flush_if_id}, {31'd0, e_fl});
      chk("rnd_fwd_rs", {30'd0, fwd_sel_rs}, {30'd0, m_sel(id_rs, id_uses_rs)});
      chk("rnd_fwd_rt", {30'd0, fwd_sel_rt}, {30'd0, m_sel(id_rt, id_uses_rt)});
      chk("rnd_stage_valid", {29'd0, stage_valid}, {29'd0, e_sv});
      chk("rnd_stall_count", stall_count, m_cnt);
      @(posedge clk);
      for (int i = NS - 1; i >= 1; i--) hist[i] = hist[i-1];
      if (ex_branch_taken || e_st) hist[0] = '{0, 0, 0, 0};
      else hist[0] = '{id_valid, id_dest, id_reg_write, id_mem_read};
      if (e_st) m_cnt = m_cnt + 1;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
